root_local_arbiter: RTL

//   Shares the LOCAL injection port of the root quadtree router between two

---
 rtl/root_local_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/root_local_arbiter.sv
// root_local_arbiter
//   Shares the root router's LOCAL injection port between the write-request
//   and read-request flit sources. Round-robin with bounded bursts, a credit
//   counter mirroring free slots in the router's LOCAL input buffer, and a
//   registered flit output.
module root_local_arbiter #(
   parameter int FLIT_WIDTH  = 32,
   parameter int CREDIT_INIT = 4,
   parameter int MAX_BURST   = 2,
   localparam int CW         = $clog2(CREDIT_INIT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_flit_valid,
   input  logic [FLIT_WIDTH-1:0] wr_flit,
   output logic                  wr_flit_ready,
   input  logic                  rd_flit_valid,
   input  logic [FLIT_WIDTH-1:0] rd_flit,
   output logic                  rd_flit_ready,
   output logic                  out_data_valid,
   output logic [FLIT_WIDTH-1:0] out_data,
   input  logic                  downstream_credit,
   output logic [CW-1:0]         credit_cnt,
   output logic                  credit_err
);

   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_INIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t                state_r;
   logic [BW-1:0]         burst_r;
   logic                  last_rd_r;      // 1: read path was served last
   logic [CW-1:0]         credit_cnt_r;
   logic                  credit_err_r;
   logic                  out_valid_r;
   logic [FLIT_WIDTH-1:0] out_data_r;

   logic credit_avail_s;
   logic wr_ready_s;
   logic rd_ready_s;
   logic wr_accept_s;
   logic rd_accept_s;
   logic send_s;

   // Ready depends only on state and credits, so only one source can ever be ready.
   always_comb begin
      credit_avail_s = (credit_cnt_r != {CW{1'b0}});
      wr_ready_s     = (state_r == ST_WR) && credit_avail_s;
      rd_ready_s     = (state_r == ST_RD) && credit_avail_s;
      wr_accept_s    = wr_flit_valid && wr_ready_s;
      rd_accept_s    = rd_flit_valid && rd_ready_s;
      send_s         = wr_accept_s || rd_accept_s;
   end

   // Arbitration FSM: picks a source in IDLE, then serves it for up to MAX_BURST flits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         burst_r   <= {BW{1'b0}};
         last_rd_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               burst_r <= {BW{1'b0}};
               if (wr_flit_valid && rd_flit_valid) begin
                  state_r <= last_rd_r ? ST_WR : ST_RD;
               end else if (wr_flit_valid) begin
                  state_r <= ST_WR;
               end else if (rd_flit_valid) begin
                  state_r <= ST_RD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WR: begin
               if (wr_accept_s && (burst_r == BURST_LAST)) begin
                  burst_r   <= {BW{1'b0}};
                  last_rd_r <= 1'b0;
                  state_r   <= rd_flit_valid ? ST_RD : ST_WR;
               end else if (!wr_flit_valid) begin
                  burst_r <= {BW{1'b0}};
                  state_r <= rd_flit_valid ? ST_RD : ST_IDLE;
               end else begin
                  // Credit stall leaves the burst count untouched.
                  burst_r <= burst_r + BW'(wr_accept_s);
               end
            end
            ST_RD: begin
               if (rd_accept_s && (burst_r == BURST_LAST)) begin
                  burst_r   <= {BW{1'b0}};
                  last_rd_r <= 1'b1;
                  state_r   <= wr_flit_valid ? ST_WR : ST_RD;
               end else if (!rd_flit_valid) begin
                  burst_r <= {BW{1'b0}};
                  state_r <= wr_flit_valid ? ST_WR : ST_IDLE;
               end else begin
                  burst_r <= burst_r + BW'(rd_accept_s);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               burst_r <= {BW{1'b0}};
            end
         endcase
      end
   end

   // Output register: the accepted flit appears one cycle after acceptance; data holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {FLIT_WIDTH{1'b0}};
      end else begin
         out_valid_r <= send_s;
         if (wr_accept_s) begin
            out_data_r <= wr_flit;
         end else if (rd_accept_s) begin
            out_data_r <= rd_flit;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

   // Credit tracking: a send consumes a slot, a returned credit frees one; overflow is flagged sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt_r <= CREDIT_FULL;
         credit_err_r <= 1'b0;
      end else begin
         case ({send_s, downstream_credit})
            2'b10: credit_cnt_r <= credit_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            2'b01: begin
               if (credit_cnt_r == CREDIT_FULL) begin
                  credit_err_r <= 1'b1;
               end else begin
                  credit_cnt_r <= credit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: credit_cnt_r <= credit_cnt_r;
         endcase
      end
   end

   assign wr_flit_ready  = wr_ready_s;
   assign rd_flit_ready  = rd_ready_s;
   assign out_data_valid = out_valid_r;
   assign out_data       = out_data_r;
   assign credit_cnt     = credit_cnt_r;
   assign credit_err     = credit_err_r;

endmodule
